// File: rtl/instruction_buffer_pkg.sv
// ---------------------------------------------------------------------------
// instruction_buffer_pkg
// Shared types and sizing for the fetch -> dispatch instruction buffer.
//   FETCH_ENTRY  : one fetched instruction (inst, PC, NPC, predicted_taken)
//   FETCH_PACKET : IB_N_DEF fetch entries, lane 0 oldest
//   IB_DEBUG     : head/tail/count snapshot plus per-entry valid bitmap
//                  (only driven when IB_DEBUG_EN is defined)
// ---------------------------------------------------------------------------
package instruction_buffer_pkg;

  localparam int IB_N_DEF        = 3;   // superscalar width
  localparam int IB_SZ_DEF       = 16;  // entry count, power of two, >= 2*N
  localparam int IB_SZ_BITS      = $clog2(IB_SZ_DEF);
  localparam int NUM_SCALAR_BITS = $clog2(IB_N_DEF + 1);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        predicted_taken;
  } FETCH_ENTRY;

  typedef FETCH_ENTRY [IB_N_DEF-1:0] FETCH_PACKET;

  typedef struct packed {
    logic [IB_SZ_BITS-1:0] head;
    logic [IB_SZ_BITS-1:0] tail;
    logic [IB_SZ_BITS:0]   count;
    logic [IB_SZ_DEF-1:0]  valid_map;
  } IB_DEBUG;

endpackage

// File: rtl/instruction_buffer_if.sv
// ---------------------------------------------------------------------------
// instruction_buffer_if
// Fetch/dispatch side bundle of the instruction buffer.
//   fetch_packets, fetch_valid : fetched lanes offered this cycle
//   ib_spots                   : lanes the buffer can accept this cycle
//   instruction_packets        : oldest entries, lane 0 = head
//   instructions_valid         : number of valid output lanes
//   num_dispatched             : lanes consumed by dispatch this cycle
//   flush                      : squash all buffered instructions
// Modports: master = fetch/dispatch side, slave = buffer.
// ---------------------------------------------------------------------------
interface instruction_buffer_if import instruction_buffer_pkg::*; ();

  FETCH_PACKET                fetch_packets;
  logic [NUM_SCALAR_BITS-1:0] fetch_valid;
  logic [NUM_SCALAR_BITS-1:0] ib_spots;
  FETCH_PACKET                instruction_packets;
  logic [NUM_SCALAR_BITS-1:0] instructions_valid;
  logic [NUM_SCALAR_BITS-1:0] num_dispatched;
  logic                       flush;

  modport master (
    output fetch_packets, fetch_valid, num_dispatched, flush,
    input  ib_spots, instruction_packets, instructions_valid
  );

  modport slave (
    input  fetch_packets, fetch_valid, num_dispatched, flush,
    output ib_spots, instruction_packets, instructions_valid
  );

endinterface

// File: rtl/instruction_buffer.sv
// ---------------------------------------------------------------------------
// instruction_buffer
// N-wide circular FIFO between fetch and dispatch. Accepts up to N fetched
// instructions per cycle, presents the N oldest in program order, and is
// emptied in one cycle by flush. All outputs depend on registered state only.
//
// Ports:
//   clock     : rising-edge clock
//   reset     : asynchronous, active-low
//   ib        : instruction_buffer_if.slave (fetch in, dispatch out, flush)
//   ib_debug  : IB_DEBUG snapshot (only with IB_DEBUG_EN)
//
// Build option IB_DEBUG_EN: adds the ib_debug port and protocol assertions.
// The packet types in the package fix the lane count and entry count, so N
// and IB_SZ must match IB_N_DEF / IB_SZ_DEF.
// ---------------------------------------------------------------------------
module instruction_buffer import instruction_buffer_pkg::*; #(
  parameter int N     = IB_N_DEF,
  parameter int IB_SZ = IB_SZ_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  instruction_buffer_if.slave  ib
`ifdef IB_DEBUG_EN
  ,
  output IB_DEBUG              ib_debug
`endif
);

  localparam int IDX_W = $clog2(IB_SZ);
  localparam int CNT_W = IDX_W + 1;
  localparam int SB_W  = NUM_SCALAR_BITS;

  function automatic logic [CNT_W-1:0] sat_min(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  logic [IDX_W-1:0] head_q;
  logic [IDX_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  FETCH_ENTRY       entries [IB_SZ];

  logic [CNT_W-1:0] spots_w;
  logic [CNT_W-1:0] avail_w;
  logic [CNT_W-1:0] pops_w;
  logic [CNT_W-1:0] pushes_w;
  FETCH_PACKET      rd_pkt;

  // Occupancy-derived limits: free space is taken from the start-of-cycle
  // count, so entries popped this cycle are only offered next cycle.
  always_comb begin
    spots_w  = sat_min(CNT_W'(IB_SZ) - count_q, CNT_W'(N));
    avail_w  = sat_min(count_q, CNT_W'(N));
    pops_w   = sat_min(CNT_W'(ib.num_dispatched), avail_w);
    pushes_w = sat_min(CNT_W'(ib.fetch_valid), spots_w);
  end

  always_comb begin
    rd_pkt = '0;
    for (int k = 0; k < N; k++) begin
      rd_pkt[k] = entries[head_q + IDX_W'(k)];
    end
  end

  assign ib.instruction_packets = rd_pkt;
  assign ib.instructions_valid  = avail_w[SB_W-1:0];
  assign ib.ib_spots            = spots_w[SB_W-1:0];

  // Pointer / occupancy registers; flush wins over same-cycle traffic.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (ib.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + pops_w[IDX_W-1:0];
      tail_q  <= tail_q + pushes_w[IDX_W-1:0];
      count_q <= count_q + pushes_w - pops_w;
    end
  end

  // Entry storage: writes beyond the free space are dropped by pushes_w.
  // Data written while in reset lands beyond count and is never exposed.
  always_ff @(posedge clock) begin
    if (!ib.flush) begin
      for (int k = 0; k < N; k++) begin
        if (CNT_W'(k) < pushes_w) begin
          entries[tail_q + IDX_W'(k)] <= ib.fetch_packets[k];
        end
      end
    end
  end

`ifdef IB_DEBUG_EN
  always_comb begin
    ib_debug       = '0;
    ib_debug.head  = head_q;
    ib_debug.tail  = tail_q;
    ib_debug.count = count_q;
    for (int i = 0; i < IB_SZ; i++) begin
      // An entry is live when its distance from head is below count.
      ib_debug.valid_map[i] = {1'b0, IDX_W'(i) - head_q} < count_q;
    end
  end

  always_ff @(posedge clock) begin
    assert (ib.fetch_valid <= ib.ib_spots)
      else begin $error("fetch_valid exceeds ib_spots"); $finish; end
    assert (ib.num_dispatched <= ib.instructions_valid)
      else begin $error("num_dispatched exceeds instructions_valid"); $finish; end
    assert (count_q <= CNT_W'(IB_SZ))
      else begin $error("count exceeds IB_SZ"); $finish; end
  end
`endif

endmodule
